// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   FETCH_XLEN      instruction/address width carried in a fetch entry
//   FETCH_RESET_PC  default first fetch address after reset
//   INSTR_NOP       canonical no-op encoding (addi x0, x0, 0)
//   fetch_entry_t   {pc, instr} payload held in the prefetch FIFO
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;

    localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [FETCH_XLEN-1:0] INSTR_NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular prefetch buffer of fetch_entry_t.
// Ports:
//   clk        clock
//   rst        synchronous active-low reset
//   push       write wdata at the tail
//   wdata      entry to write
//   pop        retire the head entry
//   flush      discard all entries (overrides push/pop)
//   head       entry at the read pointer (meaningful when occupancy != 0)
//   occupancy  number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 wdata,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            occupancy <= occupancy + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents need no reset since occupancy qualifies them.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the fetch PC, issues word reads
// to a synchronous instruction memory (data one cycle after the request),
// buffers {pc, instr} in a prefetch FIFO and hands them to decode over a
// valid/ready handshake. A redirect flushes buffered and in-flight fetches
// and restarts at redirect_pc.
// Ports:
//   clk, rst                clock, synchronous active-low reset
//   imem_req, imem_addr     read request / word address (addr always = fetch pc)
//   imem_rdata              instruction returned one cycle after imem_req
//   redirect_valid/_pc      taken branch/jump and its target
//   out_valid/out_ready     decode handshake
//   out_pc, out_instr       head entry, zero while out_valid=0
//   misalign_err            sticky misaligned-redirect fault
// Build option: FETCH_ALIGN_CHECK_EN enables misaligned-redirect detection
// (fault + fetch halt); otherwise the target's low two bits are cleared.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = FETCH_XLEN,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = FETCH_RESET_PC,
    parameter int unsigned           DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic                  misalign_err
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned UW = CW + 1;

    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic [CW-1:0]         occupancy;
    fetch_entry_t          head;
    fetch_entry_t          push_entry_c;

    logic                  pop_c;
    logic                  push_c;
    logic                  issue_c;
    logic                  halt_c;
    logic [UW-1:0]         used_c;
    logic [DATA_WIDTH-1:0] redirect_target_c;

`ifdef FETCH_ALIGN_CHECK_EN
    // A misaligned redirect faults and freezes fetch until reset.
    assign halt_c            = misalign_err;
    assign redirect_target_c = redirect_pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign_err <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end
`else
    assign halt_c            = 1'b0;
    assign redirect_target_c = redirect_pc & ~DATA_WIDTH'(3);
    assign misalign_err      = 1'b0;
`endif

    // Credit check counts this cycle's pop, so a full FIFO being drained
    // still allows a request and sustains one instruction per cycle.
    always_comb begin
        pop_c   = 1'b0;
        used_c  = '0;
        issue_c = 1'b0;
        push_c  = 1'b0;
        pop_c   = out_valid & out_ready;
        used_c  = UW'(occupancy) + UW'(inflight) - UW'(pop_c);
        issue_c = rst & ~redirect_valid & ~halt_c & (used_c < UW'(DEPTH));
        push_c  = rst & inflight & ~redirect_valid;
    end

    assign push_entry_c.pc    = FETCH_XLEN'(inflight_pc);
    assign push_entry_c.instr = FETCH_XLEN'(imem_rdata);

    // Fetch PC and in-flight tracking; redirect has top priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target_c;
            inflight <= 1'b0;
        end else begin
            inflight <= issue_c;
            if (issue_c) begin
                fetch_pc    <= fetch_pc + DATA_WIDTH'(4);
                inflight_pc <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .wdata     (push_entry_c),
        .pop       (pop_c),
        .flush     (redirect_valid),
        .head      (head),
        .occupancy (occupancy)
    );

    assign imem_req  = issue_c;
    assign imem_addr = fetch_pc;
    assign out_valid = (occupancy != '0);
    assign out_pc    = out_valid ? DATA_WIDTH'(head.pc)    : '0;
    assign out_instr = out_valid ? DATA_WIDTH'(head.instr) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed stimulus for fetch_unit against a
// queue-based reference model. The driver issues per-cycle stimulus and pushes
// expected {pc, instr} entries into a scoreboard; a separate monitor pops and
// compares whenever decode accepts an instruction.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic          clk;
    logic          rst;
    logic          imem_req;
    logic [DW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          redirect_valid;
    logic [DW-1:0] redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_pc;
    logic [DW-1:0] out_instr;
    logic          misalign_err;

    fetch_unit #(
        .DATA_WIDTH (DW),
        .RESET_PC   (RST_PC),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    fetch_entry_t sb[$];
    logic         m_inflight;
    logic [31:0]  m_inflight_pc;
    logic [31:0]  m_pc;
    logic         m_err;
    logic         mon_en;
    logic         last_req;
    logic [31:0]  last_addr;
    int           req_count;

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the handshake against the scoreboard each cycle.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
                if (sb.size() == 0) begin
                    check("out_pc_idle", out_pc, 32'h0);
                    check("out_instr_idle", out_instr, 32'h0);
                end else if (out_ready) begin
                    e = sb.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_instr", out_instr, e.instr);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b0;
        mon_en         = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rdata     = $urandom();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'h0);
        sb.delete();
        m_inflight    = 1'b0;
        m_inflight_pc = '0;
        m_pc          = RST_PC;
        m_err         = 1'b0;
        last_req      = 1'b0;
        last_addr     = '0;
    endtask

    // One clock of stimulus plus the model's view of that cycle.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
        int   sz0;
        logic mpop;
        logic exp_issue;
        @(negedge clk);
        rst            = 1'b1;
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rdata     = last_req ? instr_of(last_addr) : $urandom();
        sz0            = sb.size();
        mon_en         = 1'b1;
        mpop           = (sz0 != 0) && rdy;
        #2;
        exp_issue = !redir && !m_err &&
                    ((sz0 + int'(m_inflight) - int'(mpop)) < int'(DEPTH));
        check("imem_req", 32'(imem_req), 32'(exp_issue));
        check("imem_addr", imem_addr, m_pc);
        check("misalign_err", 32'(misalign_err), 32'(m_err));
        check("occupancy", 32'(dut.occupancy), 32'(sz0));
        check("no_overflow", 32'(dut.push_c & ~dut.pop_c & (dut.occupancy == DEPTH)), 32'h0);
        last_req  = imem_req;
        last_addr = imem_addr;
        if (imem_req) req_count++;
        if (redir) begin
            sb.delete();
            m_inflight = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (rpc[1:0] != 2'b00) m_err = 1'b1;
            m_pc = rpc;
`else
            m_pc = {rpc[31:2], 2'b00};
`endif
        end else begin
            if (m_inflight) begin
                sb.push_back('{pc: m_inflight_pc, instr: instr_of(m_inflight_pc)});
            end
            if (exp_issue) begin
                m_inflight_pc = m_pc;
                m_pc          = m_pc + 32'd4;
            end
            m_inflight = exp_issue;
        end
    endtask

    initial begin
        int base;
        logic [31:0] rpc;
        rst = 1'b0; mon_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; imem_rdata = '0; req_count = 0;
        last_req = 1'b0; last_addr = '0; m_err = 1'b0;

        // Streaming with decode always ready
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);

        // Back-pressure: only DEPTH requests issue, then resume without gaps
        do_reset();
        base = req_count;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
        check("stall_req_count", 32'(req_count - base), 32'(DEPTH));
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);

        // Redirect while buffered and in flight
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

        // Redirect coinciding with a pop and a response
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0200);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);

        // Address wrap at the top of the address space
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

        // Misaligned redirect: aligned down, or fault and halt when checked
        step(1'b1, 1'b1, 32'h0000_0102);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
        do_reset();

        // Randomized traffic with occasional redirects and resets
        for (int i = 0; i < 800; i++) begin
            rpc = (($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : 32'h0) | $urandom();
`ifdef FETCH_ALIGN_CHECK_EN
            rpc[1:0] = 2'b00;
`endif
            step($urandom_range(3) != 0, $urandom_range(15) == 0, rpc);
            if ($urandom_range(149) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the single-cycle datapath's decode, control and register-file logic. Owns the fetch PC, issues word reads to the synchronous instruction memory, and buffers returned instructions with their PCs in a small prefetch FIFO. Presents them to decode over a valid/ready handshake. A branch/jump redirect from the execute side flushes all buffered and in-flight fetches and restarts fetch at the new target.

## Interface
- DATA_WIDTH, 32, instruction and address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, prefetch FIFO entries; power of two, ≥2

- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, synchronous, active-low (asserted when 0)
- imem_req  output  1  read request this cycle
- imem_addr  output  DATA_WIDTH  word address of the request
- imem_rdata  input  DATA_WIDTH  instruction, valid exactly one cycle after imem_req
- redirect_valid  input  1  taken branch/jump; flush and restart
- redirect_pc  input  DATA_WIDTH  restart target
- out_valid  output  1  FIFO head holds an instruction
- out_ready  input  1  decode accepts the head
- out_pc  output  DATA_WIDTH  PC of head instruction
- out_instr  output  DATA_WIDTH  head instruction
- misalign_err  output  1  sticky alignment fault (only with FETCH_ALIGN_CHECK_EN)

## Operation
- State:
  - fetch_pc (next address to request)
  - inflight flag plus inflight_pc (request issued last cycle)
  - FIFO of {pc, instr}
  - occupancy count 0..DEPTH
- pop = out_valid & out_ready. Pop removes the head.
- Issue condition: not redirect_valid, and (occupancy + inflight − pop) < DEPTH. When it holds:
  - imem_req=1, imem_addr=fetch_pc
  - fetch_pc += 4 (mod 2^DATA_WIDTH, wraps silently)
  - inflight ← 1, inflight_pc ← fetch_pc
  - Otherwise inflight ← 0.
- imem_addr always shows fetch_pc, including while imem_req=0.
- Response: if inflight and no redirect this cycle, push {inflight_pc, imem_rdata}. Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Redirect (highest priority):
  - occupancy ← 0, inflight ← 0; this cycle's imem_rdata is discarded.
  - fetch_pc ← redirect_pc; no request issued this cycle.
  - A pop coinciding with the redirect completes for the consumer, but the FIFO is cleared regardless.
- The credit rule makes overflow impossible. A push into a full FIFO is a design error (bench assertion).
- out_pc/out_instr are forced to 0 whenever out_valid=0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0, misalign_err=0. fetch_pc=RESET_PC, occupancy=0, inflight=0.
- First cycle after rst deasserts: imem_req=1, addr RESET_PC.
- Request in cycle N → entry written at end of N+1 → out_valid in N+2. Fetch-to-valid latency is 2 cycles, with no bypass.
- Steady state with out_ready=1: one instruction per cycle for any DEPTH≥2.
- out_ready=0: requests stop once occupancy+inflight reaches DEPTH. The in-flight word is still captured.
- Redirect in cycle R: out_valid=0 in R+1, request at redirect_pc in R+1, out_valid=1 in R+3.
- rst asserted mid-operation: next edge returns all state to reset values; in-flight data dropped.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0]≠0 sets misalign_err (sticky until reset).
  - Performs the flush but issues no further requests (fetch halts).
  - Aligned redirects behave normally.
- Undefined: misalign_err is tied 0. redirect_pc[1:0] is ignored (forced to 00 when loaded into fetch_pc).

## Structure
- Package fetch_pkg:
  - typedef fetch_entry_t {pc, instr}
  - FETCH_RESET_PC default constant
  - INSTR_NOP = 32'h0000_0013
- Sub-module fetch_fifo:
  - DEPTH-entry circular buffer of fetch_entry_t
  - push/pop/flush inputs, occupancy output
  - Read and write pointers wrap modulo DEPTH.
- fetch_unit holds the PC, credit and redirect logic.

## Test plan
- Reset release, out_ready=1, imem returns addr-indexed words → out_valid first in cycle 2; PCs 0,4,8,… one per cycle with matching instructions.
- out_ready=0 for 6 cycles after start, DEPTH=2 → exactly 2 requests issued, occupancy 2, imem_req=0 thereafter; on release, PCs continue 0,4,8 with no gap or duplicate.
- Redirect to 0x100 while FIFO full and a request in flight → out_valid=0 next cycle, request 0x100 next cycle, first output pc=0x100 two cycles later; stale word never appears.
- Redirect asserted in the same cycle as a pop and a response → pop accepted, response dropped, occupancy 0 next cycle.
- fetch_pc at 0xFFFF_FFFC → next request wraps to 0x0000_0000.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x102 → misalign_err=1 next cycle, imem_req stays 0, out_valid stays 0 until rst asserted.
